sorted_stream_tx: RTL and testbench
===================================

// Module: sorted_stream_tx
// PURPOSE
//  Transmit side of the 4-lane sorter: accepts one sorted tuple (smallest on lane A, largest on D)
//  per valid/ready handshake, buffers it, and serialises it onto a one-value-per-beat stream.
//  Sits downstream of sorter4; each beat carries its rank index and a last flag.
//  Emission order is selectable per tuple (ascending/descending); tuple ordering is checked on accept.
// PARAMETERS
//  WIDTH    4   bits per value
//  LANES    4   values per tuple (fixed at 4 in this revision; other values are unsupported)
//  ERRW     8   width of saturating order-error counter
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        tuple present on InA..InD
//  in_ready   out  1        block can take a tuple this cycle
//  InA        in   WIDTH    rank 0 (smallest)
//  InB        in   WIDTH    rank 1
//  InC        in   WIDTH    rank 2
//  InD        in   WIDTH    rank 3 (largest)
//  in_desc    in   1        sampled on accept: 1 = emit D,C,B,A; 0 = emit A,B,C,D
//  out_valid  out  1        beat present
//  out_ready  in   1        sink takes beat when out_valid & out_ready
//  out_data   out  WIDTH    current value
//  out_idx    out  2        rank of out_data (0=A..3=D)
//  out_last   out  1        final beat of tuple
//  order_err  out  1        one-cycle pulse: accepted tuple was not A<=B<=C<=D
//  err_count  out  ERRW     saturating count of order_err pulses
// BEHAVIOUR
//  - Reset (rst=1 at edge): state IDLE, buffer cleared to 0, beat counter 0, out_valid=0, out_data=0,
//    out_idx=0, out_last=0, order_err=0, err_count=0. in_ready is 0 while rst=1, 1 in IDLE after.
//    Reset mid-tuple discards the buffered tuple; no further beats of it are emitted.
//  - FSM: IDLE -> SEND on accept (in_valid & in_ready). SEND -> IDLE when last beat handed off and no
//    new tuple accepted; SEND -> SEND (reload) when last beat handed off and a new tuple accepted same cycle.
//  - in_ready = IDLE | (SEND & out_valid & out_ready & out_last): back-to-back tuples, zero bubble.
//  - Latency: tuple accepted at edge N -> first beat valid after edge N (registered, visible cycle N+1).
//  - One beat advances per cycle with out_ready=1; out_ready=0 holds out_data/out_idx/out_last stable.
//    out_valid never drops until its beat is handed off.
//  - Beat counter k=0..3; out_idx = in_desc_q ? 3-k : k; out_last = (k==3). Counter wraps 3->0 on handoff.
//  - Compare unsigned. order_err pulses the cycle after accept iff any of A>B, B>C, C>D. Tuple is still
//    sent unaltered. err_count += 1 per pulse, holds at 2^ERRW-1.
//  - in_valid with in_ready=0 is ignored (no accept, no check); in_desc only sampled on accept.
//  - Equal values are legal order (no error).
// STRUCTURE
//  - sorter_pkg: WIDTH/LANES constants, rank index type, FSM state encoding (IDLE, SEND).
//  - Sub-module sorted_check4: combinational A<=B<=C<=D check, reusable by sorter4 benches.
//  - Top holds 4xWIDTH tuple register, desc flag, 2-bit beat counter, FSM, error counter.
// TESTING
//  1. Reset, accept {A..D}={1,3,7,9}, desc=0, out_ready=1 -> beats 1,3,7,9; idx 0..3; last on 9; err=0.
//  2. Same tuple with desc=1 -> beats 9,7,3,1; idx 3,2,1,0; last on 1.
//  3. Two tuples back-to-back ({0,0,5,F} then {2,4,6,8}), out_ready=1 -> 8 consecutive valid beats,
//     in_ready high only in IDLE and on last-beat cycle, no bubble.
//  4. out_ready toggled 1,0,0,1,... during {1,2,3,4} -> each beat held stable while stalled, none lost.
//  5. Accept {5,2,7,1} -> order_err one cycle, err_count=1, beats still 5,2,7,1; 300 bad tuples with
//     ERRW=8 -> err_count saturates at 255.
//  6. rst asserted after beat idx1 of {1,3,7,9} -> next cycle out_valid=0, in_ready=1, err_count=0.

Source files
------------

// File: rtl/sorter_pkg.sv
// sorter_pkg: shared constants, rank type and FSM encoding
// for the 4-lane sorter transmit path.
package sorter_pkg;

  localparam int DATA_W    = 4;
  localparam int NUM_LANES = 4;

  typedef logic [1:0] rank_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Rank emitted on beat k for the chosen direction.
  function automatic rank_t rankOf(
    input logic  desc,
    input rank_t k
  );
    return desc ? rank_t'(2'd3 - k) : k;
  endfunction

endpackage

// File: rtl/sorted_check4.sv
// sorted_check4: combinational unsigned A<=B<=C<=D test,
// shared by the transmitter and sorter4 benches.
module sorted_check4
  import sorter_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             isSorted
);

  assign isSorted = (a <= b) && (b <= c) && (c <= d);

endmodule

// File: rtl/sorted_stream_tx.sv
// sorted_stream_tx: buffers one sorted tuple per handshake and
// serialises it as ranked beats, flagging out-of-order tuples.
module sorted_stream_tx
  import sorter_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int LANES = NUM_LANES,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  input  logic [WIDTH-1:0] InC,
  input  logic [WIDTH-1:0] InD,
  input  logic             in_desc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output rank_t            out_idx,
  output logic             out_last,
  output logic             order_err,
  output logic [ERRW-1:0]  err_count
);

  state_t           stateQ;
  logic [WIDTH-1:0] tupleQ [LANES];
  logic             descQ;
  rank_t            beatQ;

  logic  isSorted;
  logic  handoff;
  logic  accept;
  rank_t nextBeat;
  rank_t nextRank;

  sorted_check4 #(.WIDTH(WIDTH)) check (
    .a        (InA),
    .b        (InB),
    .c        (InC),
    .d        (InD),
    .isSorted (isSorted)
  );

  assign handoff  = out_valid & out_ready;
  // Reload on the last handoff keeps tuples back-to-back.
  assign in_ready = ~rst & ((stateQ == IDLE) | (handoff & out_last));
  assign accept   = in_valid & in_ready;
  assign nextBeat = beatQ + 2'd1;
  assign nextRank = rankOf(descQ, nextBeat);

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= IDLE;
      tupleQ    <= '{default: '0};
      descQ     <= 1'b0;
      beatQ     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      order_err <= 1'b0;
      err_count <= '0;
    end else begin
      order_err <= 1'b0;
      if (accept) begin
        stateQ    <= SEND;
        tupleQ    <= '{InA, InB, InC, InD};
        descQ     <= in_desc;
        beatQ     <= '0;
        out_valid <= 1'b1;
        out_data  <= in_desc ? InD : InA;
        out_idx   <= rankOf(in_desc, 2'd0);
        out_last  <= 1'b0;
        if (!isSorted) begin
          order_err <= 1'b1;
          if (err_count != '1) begin
            err_count <= err_count + 1'b1;
          end
        end
      end else if (handoff) begin
        if (out_last) begin
          stateQ    <= IDLE;
          beatQ     <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          beatQ    <= nextBeat;
          out_data <= tupleQ[nextRank];
          out_idx  <= nextRank;
          out_last <= (nextBeat == 2'd3);
        end
      end
    end
  end

endmodule

// File: tb/tb_sorted_stream_tx.sv
// tb_sorted_stream_tx: randomized and directed stimulus checked
// every cycle against a queue-based model of the beat stream.
module tb_sorted_stream_tx;

  typedef struct packed {
    logic [3:0] d;
    logic [1:0] i;
    logic       l;
  } beat_t;

  logic       clk = 0;
  logic       rst = 1;
  logic       in_valid = 0;
  logic       in_ready;
  logic [3:0] InA = 0, InB = 0, InC = 0, InD = 0;
  logic       in_desc = 0;
  logic       out_valid;
  logic       out_ready = 1;
  logic [3:0] out_data;
  logic [1:0] out_idx;
  logic       out_last;
  logic       order_err;
  logic [7:0] err_count;

  int nChecks = 0;
  int nErr    = 0;
  int orMode  = 0;
  int cyc     = 0;

  beat_t q[$];
  int    logD[$];
  int    logI[$];
  logic  expErr  = 0;
  int    expCnt  = 0;
  logic  justRst = 1;

  sorted_stream_tx #(.WIDTH(4), .LANES(4), .ERRW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .InA       (InA),
    .InB       (InB),
    .InC       (InC),
    .InD       (InD),
    .in_desc   (in_desc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .order_err (order_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (orMode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 3 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    cyc++;
  end

  // Model state reflects what the DUT must show after the next edge.
  always @(negedge clk) begin
    logic       acc;
    logic [3:0] t[4];
    int         r;
    chk("in_ready", in_ready,
        !rst && (q.size() == 0 || (q.size() == 1 && out_ready)));
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_idx", out_idx, q[0].i);
      chk("out_last", out_last, q[0].l);
    end
    chk("order_err", order_err, expErr);
    chk("err_count", err_count, expCnt);
    if (justRst) begin
      chk("rst_data", out_data, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_last", out_last, 0);
    end
    if (rst) begin
      q.delete();
      expErr  = 0;
      expCnt  = 0;
      justRst = 1;
    end else begin
      justRst = 0;
      acc = in_valid && (q.size() == 0 || (q.size() == 1 && out_ready));
      if (out_valid && out_ready) begin
        logD.push_back(int'(out_data));
        logI.push_back(int'(out_idx));
      end
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      expErr = 0;
      if (acc) begin
        t[0] = InA; t[1] = InB; t[2] = InC; t[3] = InD;
        for (int k = 0; k < 4; k++) begin
          r = in_desc ? 3 - k : k;
          q.push_back('{d: t[r], i: 2'(r), l: (k == 3)});
        end
        if (InA > InB || InB > InC || InC > InD) begin
          expErr = 1;
          if (expCnt < 255) expCnt++;
        end
      end
    end
  end

  task automatic sendTuple(input logic [3:0] a, b, c, d,
                           input logic desc);
    int n = 0;
    InA = a; InB = b; InC = c; InD = d;
    in_desc  = desc;
    in_valid = 1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 500) begin
        nChecks++;
        nErr++;
        $display("FAIL accept_timeout: got no in_ready expected one");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    InA = 4'($urandom); InB = 4'($urandom);
    InC = 4'($urandom); InD = 4'($urandom);
    in_desc = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!out_valid) break;
      if (++n > 500) begin
        nChecks++;
        nErr++;
        $display("FAIL drain_timeout: got out_valid=1 expected 0");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chkLog(input string name, input int d[4], input int i[4]);
    chk({name, "_count"}, logD.size(), 4);
    for (int k = 0; k < 4 && k < logD.size(); k++) begin
      chk({name, "_data"}, logD[k], d[k]);
      chk({name, "_idx"}, logI[k], i[k]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected one");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] v[4];
    logic [3:0] tmp;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;

    orMode = 0;
    logD.delete(); logI.delete();
    sendTuple(1, 3, 7, 9, 0);
    drain();
    chkLog("asc", '{1, 3, 7, 9}, '{0, 1, 2, 3});

    logD.delete(); logI.delete();
    sendTuple(1, 3, 7, 9, 1);
    drain();
    chkLog("desc", '{9, 7, 3, 1}, '{3, 2, 1, 0});

    logD.delete(); logI.delete();
    sendTuple(0, 0, 5, 15, 0);
    sendTuple(2, 4, 6, 8, 0);
    drain();
    chk("b2b_count", logD.size(), 8);
    if (logD.size() == 8) begin
      chk("b2b_d3", logD[3], 15);
      chk("b2b_d4", logD[4], 2);
      chk("b2b_d7", logD[7], 8);
    end

    orMode = 1;
    @(posedge clk);
    #1;
    logD.delete(); logI.delete();
    sendTuple(1, 2, 3, 4, 0);
    drain();
    chkLog("stall", '{1, 2, 3, 4}, '{0, 1, 2, 3});

    orMode = 0;
    @(posedge clk);
    #1;
    logD.delete(); logI.delete();
    sendTuple(5, 2, 7, 1, 0);
    @(negedge clk);
    chk("bad_pulse", order_err, 1);
    chk("bad_count", err_count, 1);
    drain();
    chk("bad_pulse_gone", order_err, 0);
    chkLog("bad", '{5, 2, 7, 1}, '{0, 1, 2, 3});

    for (int n = 0; n < 300; n++) sendTuple(5, 2, 7, 1, 1'($urandom));
    drain();
    chk("saturate", err_count, 255);

    logD.delete(); logI.delete();
    sendTuple(1, 3, 7, 9, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_count", err_count, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_beats", logD.size(), 2);

    for (int n = 0; n < 150; n++) begin
      orMode = $urandom_range(0, 2);
      for (int k = 0; k < 4; k++) v[k] = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int x = 0; x < 3; x++)
          for (int y = 0; y < 3 - x; y++)
            if (v[y] > v[y + 1]) begin
              tmp = v[y]; v[y] = v[y + 1]; v[y + 1] = tmp;
            end
      end
      sendTuple(v[0], v[1], v[2], v[3], 1'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    orMode = 0;
    drain();
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
    $finish;
  end

endmodule
